// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the mod_counter family.
//   - DIR_UP / DIR_DOWN : encoding of the dir input
//   - MODE_WRAP / MODE_SAT : values of the SATURATE parameter
//   - step_action_e : what the core does with the count on a given edge
//   - clog2 / presc_width : sizing helpers for the prescaler register
// ---------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam bit   MODE_WRAP = 1'b0;
    localparam bit   MODE_SAT  = 1'b1;

    // One decision per edge; reset is handled separately in the state register.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_CLEAR,
        ACT_LOAD,
        ACT_INC,
        ACT_DEC,
        ACT_WRAP_TO_MIN,
        ACT_WRAP_TO_MAX,
        ACT_BLOCK
    } step_action_e;

    // Ceiling log2 of value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A prescaler always needs at least one bit so the register stays legal
    // even when the ratio is 1 and it never leaves zero.
    function automatic int presc_width(input int div);
        return (div <= 1) ? 1 : clog2(div);
    endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// ---------------------------------------------------------------------------
// mod_counter_prescaler
//   Divides the count enable by DIV: produces one step strobe for every DIV
//   enabled cycles. The phase is frozen while en is low.
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   en        in   count enable; the prescaler only advances while high
//   clr_sync  in   synchronous restart of the prescaler phase
//   step      out  combinational strobe, high on the last enabled cycle of a period
// ---------------------------------------------------------------------------
module mod_counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr_sync,
    output logic step
);

    localparam int unsigned W = presc_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] presc_q;
    logic [W-1:0] presc_nxt;

    // The step fires on the enabled cycle that completes a period, so the
    // count moves on the same edge the prescaler returns to zero.
    assign step = en & (presc_q == LAST);

    // Next phase: restart on clear, advance only while enabled, and roll back
    // to zero on the step cycle. With DIV == 1 LAST is 0, so this stays 0.
    always_comb begin
        presc_nxt = presc_q;
        if (clr_sync) begin
            presc_nxt = '0;
        end else if (en) begin
            presc_nxt = step ? '0 : presc_q + W'(1);
        end
    end

    // Phase register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_nxt;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
//   Up/down modulo counter (range 0..MAX) with enable prescaler, synchronous
//   clear and load, wrap or saturate behaviour at the bounds, a registered
//   one-cycle wrap pulse and a sticky overflow flag.
// Parameters
//   N         count width in bits
//   MAX       terminal value, count range 0..MAX
//   DIV       prescale ratio, one step per DIV enabled cycles
//   SATURATE  MODE_WRAP: wrap at the bounds, MODE_SAT: hold at the bounds
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   en     in   count enable (gates the prescaler)
//   dir    in   1 counts up, 0 counts down
//   clr    in   synchronous clear of count, prescaler and ovf
//   load   in   synchronous load of d (clamped to MAX)
//   d      in   load value
//   count  out  current count (registered)
//   tc     out  terminal count in the current direction (combinational)
//   wrap   out  one-cycle pulse after an edge that crossed a bound
//   ovf    out  sticky: set on any wrap or blocked saturating step
// ---------------------------------------------------------------------------
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX      = 9,
    parameter int unsigned DIV      = 1,
    parameter bit          SATURATE = MODE_WRAP
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         dir,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         wrap,
    output logic         ovf
);

    localparam logic [N-1:0] MAX_V = N'(MAX);

    logic         step;
    logic         at_max;
    logic         at_zero;
    logic [N-1:0] load_val;
    step_action_e action;

    logic [N-1:0] count_q;
    logic [N-1:0] count_nxt;
    logic         wrap_q;
    logic         wrap_nxt;
    logic         ovf_q;
    logic         ovf_nxt;

    // Both clear and load restart the prescaler phase.
    mod_counter_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr_sync (clr | load),
        .step     (step)
    );

    // Bounds are tested before any +/-1, so the arithmetic never needs an
    // extra carry bit and the count can never leave 0..MAX.
    assign at_max   = (count_q == MAX_V);
    assign at_zero  = (count_q == '0);
    assign load_val = (d > MAX_V) ? MAX_V : d;

    assign count = count_q;
    assign tc    = (dir == DIR_UP) ? at_max : at_zero;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;

    // Decide what this edge does: clear beats load beats step, and a step at
    // a bound either wraps or is blocked depending on the mode.
    always_comb begin
        action = ACT_HOLD;
        if (clr) begin
            action = ACT_CLEAR;
        end else if (load) begin
            action = ACT_LOAD;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (!at_max) begin
                    action = ACT_INC;
                end else if (SATURATE == MODE_SAT) begin
                    action = ACT_BLOCK;
                end else begin
                    action = ACT_WRAP_TO_MIN;
                end
            end else begin
                if (!at_zero) begin
                    action = ACT_DEC;
                end else if (SATURATE == MODE_SAT) begin
                    action = ACT_BLOCK;
                end else begin
                    action = ACT_WRAP_TO_MAX;
                end
            end
        end
    end

    // Turn the chosen action into next-state values. wrap defaults low so it
    // is only ever a single-cycle pulse; ovf holds unless set or cleared.
    always_comb begin
        count_nxt = count_q;
        wrap_nxt  = 1'b0;
        ovf_nxt   = ovf_q;
        unique case (action)
            ACT_CLEAR: begin
                count_nxt = '0;
                ovf_nxt   = 1'b0;
            end
            ACT_LOAD: begin
                count_nxt = load_val;
            end
            ACT_INC: begin
                count_nxt = count_q + N'(1);
            end
            ACT_DEC: begin
                count_nxt = count_q - N'(1);
            end
            ACT_WRAP_TO_MIN: begin
                count_nxt = '0;
                wrap_nxt  = 1'b1;
                ovf_nxt   = 1'b1;
            end
            ACT_WRAP_TO_MAX: begin
                count_nxt = MAX_V;
                wrap_nxt  = 1'b1;
                ovf_nxt   = 1'b1;
            end
            ACT_BLOCK: begin
                ovf_nxt   = 1'b1;
            end
            default: begin
                count_nxt = count_q;
            end
        endcase
    end

    // Count and flag registers; reset dominates everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            wrap_q  <= wrap_nxt;
            ovf_q   <= ovf_nxt;
        end
    end

endmodule
